regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of one register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; index width AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  AW, alu_data  input  WIDTH: ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports lsu_valid  input  1, lsu_rd  input  AW, lsu_data  input  WIDTH: load-unit writeback request.
REQ-008 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have ports issue_valid  input  1, issue_rd  input  AW: instruction issued that will write issue_rd.
REQ-010 SHALL have ports rs1, rs2  input  AW and rs1_busy, rs2_busy  output  1: scoreboard lookup.
REQ-011 SHALL have ports rf_write_en  output  1, rf_rd  output  AW, rf_write_data  output  WIDTH, driving the register file write port.

Function
REQ-012 SHALL accept at most one writeback per cycle; the write port is the shared resource.
REQ-013 SHALL assert alu_ready/lsu_ready combinationally, only for the granted requester, only when that requester's valid is high; both never high together.
REQ-014 SHALL grant a lone valid requester immediately.
REQ-015 SHALL arbitrate simultaneous valids round-robin: grant the requester not granted most recently (last_grant register, updated only on an accepted transfer).
REQ-016 SHALL register the accepted transfer: rf_write_en/rf_rd/rf_write_data appear exactly one cycle after acceptance and hold for one cycle.
REQ-017 SHALL drive rf_write_en low in any cycle following a cycle with no accepted transfer; rf_rd/rf_write_data hold their last values.
REQ-018 SHALL accept writebacks to rd = 0 (ready asserted, last_grant updated) but SHALL NOT assert rf_write_en for them.
REQ-019 SHALL keep a DEPTH-bit pending scoreboard; issue_valid with issue_rd != 0 sets pending[issue_rd] at the clock edge.
REQ-020 SHALL clear pending[rd] at the clock edge on which a writeback to rd is accepted.
REQ-021 SHALL give set priority when issue and accepted writeback target the same rd in the same cycle (result: pending = 1).
REQ-022 SHALL never set pending[0]; rs*_busy for index 0 is always 0.
REQ-023 SHALL compute rs1_busy = pending[rs1], rs2_busy = pending[rs2] combinationally from registered state, with no bypass of same-cycle issue or writeback.
REQ-024 SHALL accept a writeback whether or not its rd is pending; clearing a non-pending bit is a no-op.
REQ-025 SHALL keep requests ungranted in one cycle pending at the requester; no internal queueing beyond the single output register.

Reset
REQ-026 SHALL, on reset assertion, immediately force rf_write_en = 0, rf_rd = 0, rf_write_data = 0, pending = all zeros, last_grant = LSU (ALU wins the first tie).
REQ-027 SHALL keep alu_ready/lsu_ready low while reset is high; an in-flight registered write is discarded, not completed.
REQ-028 SHALL resume arbitration on the first posedge clk after reset deasserts.

Verification
REQ-029 Reset then alu_valid, alu_rd = 5, alu_data = 0xDEADBEEF one cycle -> alu_ready = 1 that cycle; next cycle rf_write_en = 1, rf_rd = 5, rf_write_data = 0xDEADBEEF; following cycle rf_write_en = 0.
REQ-030 Both valid for 4 consecutive cycles (ALU rd = 1, LSU rd = 2) from reset -> grants ALU, LSU, ALU, LSU; rf_rd sequence 1, 2, 1, 2, each one cycle later.
REQ-031 issue_valid, issue_rd = 7 -> next cycle rs1 = 7 gives rs1_busy = 1; LSU writeback rd = 7 accepted -> rs1_busy = 0 the cycle after acceptance.
REQ-032 Same-cycle issue_rd = 9 and accepted writeback rd = 9 with pending[9] = 1 -> pending[9] remains 1.
REQ-033 ALU writeback rd = 0, data = 0x12345678 -> alu_ready = 1, rf_write_en stays 0; issue_rd = 0 -> rs1 = 0 gives rs1_busy = 0.
REQ-034 Reset asserted mid-cycle right after acceptance (rd = 3) -> rf_write_en = 0 immediately, no write of rd 3 ever appears, all busy flags 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port, with a pending-write scoreboard.
// ALU and LSU share the port round-robin; each accepted transfer is registered for one cycle.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_write_en,
  output logic [AW-1:0]    rf_rd,
  output logic [WIDTH-1:0] rf_write_data
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  grant_e             last_grant_q, last_grant_d;
  logic [DEPTH-1:0]   pending_q, pending_d;
  logic               rf_write_en_q, rf_write_en_d;
  logic [AW-1:0]      rf_rd_q, rf_rd_d;
  logic [WIDTH-1:0]   rf_write_data_q, rf_write_data_d;

  logic               acc_valid;
  logic [AW-1:0]      acc_rd;
  logic [WIDTH-1:0]   acc_data;

  // On a tie, the requester that did not win last time gets the port.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!reset) begin
      if (alu_valid && (!lsu_valid || last_grant_q == GRANT_LSU)) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
  end

  always_comb begin
    acc_valid = alu_ready | lsu_ready;
    acc_rd    = alu_ready ? alu_rd : lsu_rd;
    acc_data  = alu_ready ? alu_data : lsu_data;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_ready) begin
      last_grant_d = GRANT_ALU;
    end else if (lsu_ready) begin
      last_grant_d = GRANT_LSU;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    rf_write_en_d   = acc_valid && (acc_rd != '0);
    rf_rd_d         = rf_rd_q;
    rf_write_data_d = rf_write_data_q;
    if (rf_write_en_d) begin
      rf_rd_d         = acc_rd;
      rf_write_data_d = acc_data;
    end
  end

  // Clear first, then set, so a same-cycle issue to the same rd keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (acc_valid) begin
      pending_d[acc_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q    <= GRANT_LSU;
      pending_q       <= '0;
      rf_write_en_q   <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      pending_q       <= pending_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  assign rs1_busy      = pending_q[rs1];
  assign rs2_busy      = pending_q[rs2];
  assign rf_write_en   = rf_write_en_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;

endmodule
